// File: rtl/rc_add_sub_seq.sv
// Multi-cycle ripple-carry adder/subtractor: WIDTH-bit operation processed SLICE bits per clock,
// LSB slice first, with a registered inter-slice carry and a START/BUSY/DONE handshake.
module rc_add_sub_seq #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SLICE = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SnA,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y,
    output logic             CO,
    output logic             OV,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] bx_q, bx_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;
    logic             zero_q, zero_d;

    logic [31:0]      base;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE:0]   sum;
    logic             carry_into_msb;
    logic             last;

    assign base = 32'(cnt_q) * SLICE;
    assign a_sl = a_q[base +: SLICE];
    assign b_sl = bx_q[base +: SLICE];
    assign sum  = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE + 1)'(carry_q);
    assign last = (cnt_q == CW'(NSLICE - 1));

    // Carry into the top bit of the slice recovered from the sum bit; only meaningful on the
    // last slice, where that bit is the MSB of the whole word.
    assign carry_into_msb = sum[SLICE-1] ^ a_sl[SLICE-1] ^ b_sl[SLICE-1];

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        bx_d     = bx_q;
        shadow_d = shadow_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        co_d     = co_q;
        ov_d     = ov_q;
        zero_d   = zero_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (START) begin
                    a_d      = A;
                    bx_d     = B ^ {WIDTH{SnA}};
                    carry_d  = SnA;
                    cnt_d    = '0;
                    shadow_d = '0;
                    state_d  = StRun;
                end else begin
                    state_d  = StIdle;
                end
            end
            StRun: begin
                shadow_d[base +: SLICE] = sum[SLICE-1:0];
                carry_d                 = sum[SLICE];
                cnt_d                   = cnt_q + CW'(1);
                if (last) begin
                    y_d     = shadow_d;
                    co_d    = sum[SLICE];
                    ov_d    = carry_into_msb ^ sum[SLICE];
                    zero_d  = (shadow_d == '0);
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= StIdle;
            a_q      <= '0;
            bx_q     <= '0;
            shadow_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            y_q      <= '0;
            co_q     <= 1'b0;
            ov_q     <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            bx_q     <= bx_d;
            shadow_q <= shadow_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            co_q     <= co_d;
            ov_q     <= ov_d;
            zero_q   <= zero_d;
        end
    end

    assign Y    = y_q;
    assign CO   = co_q;
    assign OV   = ov_q;
    assign ZERO = zero_q;
    assign BUSY = (state_q == StRun);
    assign DONE = (state_q == StDone);

endmodule

// File: tb/tb_rc_add_sub_seq.sv
// Bench for rc_add_sub_seq: four instances (64/8, 32/32, 32/1, 48/16) checked against an
// arithmetic reference model with directed and random operations.
module tb_rc_add_sub_seq;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sna = 1'b0;
    logic [63:0]      a_in = '0;
    logic [63:0]      b_in = '0;
    logic [3:0]       start_v = '0;
    logic [3:0][63:0] y_v;
    logic [3:0]       co_v, ov_v, zero_v, busy_v, done_v;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned W = (g == 0) ? 64 : ((g == 3) ? 48 : 32);
        localparam int unsigned S = (g == 0) ? 8 : ((g == 1) ? 32 : ((g == 2) ? 1 : 16));
        logic [W-1:0] y;
        rc_add_sub_seq #(.WIDTH(W), .SLICE(S)) u_dut (
            .CLK  (clk),
            .RST  (rst_n),
            .START(start_v[g]),
            .SnA  (sna),
            .A    (a_in[W-1:0]),
            .B    (b_in[W-1:0]),
            .Y    (y),
            .CO   (co_v[g]),
            .OV   (ov_v[g]),
            .ZERO (zero_v[g]),
            .BUSY (busy_v[g]),
            .DONE (done_v[g])
        );
        assign y_v[g] = 64'(y);
    end

    function automatic int unsigned wof(input int k);
        case (k)
            0:       return 64;
            3:       return 48;
            default: return 32;
        endcase
    endfunction

    function automatic int unsigned sof(input int k);
        case (k)
            0:       return 8;
            1:       return 32;
            2:       return 1;
            default: return 16;
        endcase
    endfunction

    // Reference: plain modular arithmetic plus sign-rule overflow.
    function automatic void model(input int unsigned w, input logic s, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] y,
                                  output logic co, output logic ov);
        logic [64:0] mask, bb, full;
        logic sa, sb, sy;
        mask = (65'd1 << w) - 65'd1;
        bb   = ({1'b0, b} ^ {65{s}}) & mask;
        full = ({1'b0, a} & mask) + bb + 65'(s);
        y    = full[63:0] & mask[63:0];
        co   = full[w];
        sa   = a[w-1];
        sb   = b[w-1];
        sy   = y[w-1];
        ov   = s ? ((sa != sb) && (sy != sa)) : ((sa == sb) && (sy != sa));
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 64'h1 << $urandom_range(0, 63);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic run_op(input int k, input logic s, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] ey, yb;
        logic        eco, eov;
        int          busy_n = 0;
        int          cyc = 0;
        model(wof(k), s, a, b, ey, eco, eov);
        @(negedge clk);
        sna = s; a_in = a; b_in = b; start_v[k] = 1'b1;
        yb = y_v[k];
        @(negedge clk);
        start_v[k] = 1'b0;
        sna = ~s; a_in = ~a; b_in = rnd64();
        chk("hold_y", y_v[k], yb);
        while (!done_v[k] && cyc < 400) begin
            if (busy_v[k]) busy_n++;
            @(negedge clk);
            cyc++;
        end
        chkb("done_seen", done_v[k], 1'b1);
        chk("busy_len", 64'(busy_n), 64'(wof(k) / sof(k)));
        chk("y", y_v[k], ey);
        chkb("co", co_v[k], eco);
        chkb("ov", ov_v[k], eov);
        chkb("zero", zero_v[k], ey == 64'h0);
        chkb("busy_at_done", busy_v[k], 1'b0);
        @(negedge clk);
        chkb("done_pulse", done_v[k], 1'b0);
    endtask

    initial begin
        logic [63:0] qy[$];
        logic        qco[$], qov[$];
        logic [63:0] ey;
        logic        eco, eov, was_done;
        int          n, cyc, last_done, dones;

        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("rst_y", y_v[k], 64'h0);
            chkb("rst_zero", zero_v[k], 1'b1);
            chkb("rst_co", co_v[k], 1'b0);
            chkb("rst_ov", ov_v[k], 1'b0);
            chkb("rst_busy", busy_v[k], 1'b0);
            chkb("rst_done", done_v[k], 1'b0);
        end
        rst_n = 1'b1;

        run_op(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        chk("d1_y", y_v[0], 64'h0);
        chkb("d1_co", co_v[0], 1'b1);
        chkb("d1_ov", ov_v[0], 1'b0);
        chkb("d1_zero", zero_v[0], 1'b1);
        run_op(0, 1'b1, 64'd5, 64'd7);
        chk("d2_y", y_v[0], 64'hFFFF_FFFF_FFFF_FFFE);
        chkb("d2_co", co_v[0], 1'b0);
        chkb("d2_zero", zero_v[0], 1'b0);
        run_op(0, 1'b1, 64'd7, 64'd5);
        chk("d3_y", y_v[0], 64'h2);
        chkb("d3_co", co_v[0], 1'b1);
        run_op(0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
        chk("d4_y", y_v[0], 64'h8000_0000_0000_0000);
        chkb("d4_ov", ov_v[0], 1'b1);
        chkb("d4_co", co_v[0], 1'b0);
        run_op(0, 1'b1, 64'h8000_0000_0000_0000, 64'h1);
        chkb("d5_ov", ov_v[0], 1'b1);
        chkb("d5_co", co_v[0], 1'b1);

        // START held high: acceptance only at the first edge and in each DONE cycle.
        @(negedge clk);
        start_v[0] = 1'b1;
        sna = 1'($urandom); a_in = rnd64(); b_in = rnd64();
        model(64, sna, a_in, b_in, ey, eco, eov);
        qy.push_back(ey); qco.push_back(eco); qov.push_back(eov);
        n = 0; cyc = 0; last_done = 0;
        while (n < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            was_done = done_v[0];
            if (was_done) begin
                chk("b2b_y", y_v[0], qy.pop_front());
                chkb("b2b_co", co_v[0], qco.pop_front());
                chkb("b2b_ov", ov_v[0], qov.pop_front());
                if (n > 0) chk("b2b_gap", 64'(cyc - last_done), 64'd9);
                last_done = cyc;
                n++;
            end
            sna = 1'($urandom); a_in = rnd64(); b_in = rnd64();
            if (was_done && n < 4) begin
                model(64, sna, a_in, b_in, ey, eco, eov);
                qy.push_back(ey); qco.push_back(eco); qov.push_back(eov);
            end
            if (n == 4) start_v[0] = 1'b0;
        end
        start_v[0] = 1'b0;
        chk("b2b_count", 64'(n), 64'd4);
        @(negedge clk);
        chkb("b2b_idle", done_v[0], 1'b0);

        // Reset in the 4th RUN cycle aborts without a DONE.
        run_op(0, 1'b0, 64'd5, 64'd7);
        @(negedge clk);
        start_v[0] = 1'b1; sna = 1'b0; a_in = 64'h1234; b_in = 64'h1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_y", y_v[0], 64'h0);
        chkb("abort_zero", zero_v[0], 1'b1);
        chkb("abort_busy", busy_v[0], 1'b0);
        chkb("abort_done", done_v[0], 1'b0);
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_v[0]) dones++;
        end
        chk("abort_nodone", 64'(dones), 64'd0);
        run_op(0, 1'b1, 64'h1_0000_0000, 64'h1);

        for (int i = 0; i < 50; i++) run_op(0, 1'($urandom), rnd64(), rnd64());
        for (int k = 1; k < 4; k++) begin
            for (int i = 0; i < 1000; i++) run_op(k, 1'($urandom), rnd64(), rnd64());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/rc_add_sub_seq.md
Name: rc_add_sub_seq

Overview:
- Parametrised, multi-cycle ripple-carry adder/subtractor; successor to the fixed-width combinational add/sub unit.
- Processes a WIDTH-bit operation in SLICE-bit chunks, one chunk per clock, LSB chunk first, carrying between chunks through a registered carry.
- Has a START/BUSY/DONE handshake and produces carry, signed-overflow and zero flags.
- Sits beside the ALU and serves wide (64-bit and up) arithmetic where single-cycle ripple timing is not acceptable.

Parameters:
- WIDTH, 64, operand/result width in bits; must be a multiple of SLICE.
- SLICE, 8, bits processed per clock; 1 <= SLICE <= WIDTH.
- NSLICE, WIDTH/SLICE, derived; cycles per operation. Not overridable.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  synchronous, active-low reset.
- START  input  1  request; sampled only when BUSY=0.
- SnA  input  1  0 = add (A+B), 1 = subtract (A-B); latched with START.
- A  input  WIDTH  operand A; latched with START.
- B  input  WIDTH  operand B; latched with START.
- Y  output  WIDTH  result; registered.
- CO  output  1  carry out of the MSB. For subtract, 1 = no borrow (A >= B unsigned).
- OV  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).
- ZERO  output  1  1 when Y == 0.
- BUSY  output  1  1 while the operation is in state RUN.
- DONE  output  1  one-cycle pulse; Y/CO/OV/ZERO are valid and newly updated.

Behaviour:
- Reset: RST sampled low at a rising edge forces state IDLE and Y=0, CO=0, OV=0, ZERO=1, BUSY=0, DONE=0. Internal operand registers, carry register and slice counter are cleared. Reset mid-operation aborts the operation with no partial result visible.
- States:
  - IDLE: BUSY=0, DONE=0. START=1 -> latch A, B XOR {WIDTH{SnA}}, carry_reg=SnA, cnt=0, clear shadow result; go to RUN.
  - RUN: BUSY=1. Each cycle adds slice cnt of A and Bx with carry_reg, writes the SLICE sum bits into the shadow result at [cnt*SLICE +: SLICE], updates carry_reg, increments cnt. When cnt==NSLICE-1, the last slice is written and the block commits: Y <= full shadow result, CO <= final carry, OV <= carry-into-MSB XOR CO, ZERO <= (committed Y == 0). Then go to DONE.
  - DONE: BUSY=0, DONE=1 for exactly one cycle. START=1 here is accepted exactly as in IDLE (back-to-back) -> RUN; otherwise -> IDLE.
- Latency: START sampled at edge k -> DONE high during the cycle after edge k+NSLICE; BUSY high for exactly NSLICE cycles.
- Result stability: Y/CO/OV/ZERO change only at commit and hold the previous result throughout RUN and IDLE.
- START while BUSY=1 is ignored; inputs are not re-sampled.
- A, B and SnA may change freely after the START cycle.
- SLICE == WIDTH: NSLICE=1; RUN lasts one cycle.
- Arithmetic: results are modulo 2^WIDTH. Subtract is A + ~B + 1, with the +1 supplied as the initial carry.

Test Plan:
- WIDTH=64, SLICE=8: START, SnA=0, A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> after 8 BUSY cycles DONE pulses; Y=0, CO=1, OV=0, ZERO=1.
- SnA=1, A=5, B=7 -> Y=0xFFFF_FFFF_FFFF_FFFE, CO=0, OV=0, ZERO=0. Then SnA=1, A=7, B=5 -> Y=2, CO=1.
- SnA=0, A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> Y=0x8000_0000_0000_0000, OV=1, CO=0. Then SnA=1, A=0x8000_0000_0000_0000, B=1 -> OV=1, CO=1.
- START held high continuously with changing operands -> START during RUN is ignored; a new operation starts in each DONE cycle; DONE every 9 cycles; each Y matches its operands latched at acceptance.
- RST low in the 4th RUN cycle -> next cycle Y=0, ZERO=1, BUSY=0, and no DONE pulse. A subsequent operation computes correctly.
- Parameter sweep (WIDTH,SLICE) = (32,32), (32,1), (48,16) with 1000 random A/B/SnA each -> Y/CO/OV match the reference model; BUSY width equals NSLICE.
